// File: rtl/gpio_nch_pkg.sv
// Shared register offsets and pin mode encodings for the parametrised GPIO slave.
package gpio_nch_pkg;

    localparam logic [7:0] GPIO_CTRL       = 8'h00;
    localparam logic [7:0] GPIO_DATA       = 8'h04;
    localparam logic [7:0] GPIO_INT_EN     = 8'h08;
    localparam logic [7:0] GPIO_INT_STATUS = 8'h0C;
    localparam logic [7:0] GPIO_DEBOUNCE   = 8'h10;

    // Encoding 2'b11 is not listed and behaves like GPIO_MODE_OFF.
    typedef enum logic [1:0] {
        GPIO_MODE_OFF = 2'b00,
        GPIO_MODE_OUT = 2'b01,
        GPIO_MODE_IN  = 2'b10
    } gpio_mode_e;

endpackage

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: two-flop synchroniser followed by a tick-sampled
// debounce that only accepts a level seen on two consecutive ticks.
module gpio_in_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pad_i,
    output logic filt_o,
    output logic filt_chg_o
);

    logic sync1_q, sync2_q, smp_q, filt_q;
    logic smp_d, filt_d;

    always_comb begin
        smp_d  = smp_q;
        filt_d = filt_q;
        if (tick) begin
            smp_d = sync2_q;
            if (sync2_q == smp_q) begin
                filt_d = sync2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            smp_q   <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            smp_q   <= smp_d;
            filt_q  <= filt_d;
        end
    end

    assign filt_o     = filt_q;
    assign filt_chg_o = (filt_d != filt_q);

endmodule

// File: rtl/gpio_nch.sv
// GPIO slave with NUM_IO pins: per-pin direction, debounced inputs and
// edge-triggered write-1-to-clear interrupt status.
module gpio_nch
    import gpio_nch_pkg::*;
#(
    parameter int NUM_IO = 2,
    parameter int DB_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [NUM_IO-1:0] io_pin_i,
    output logic [NUM_IO-1:0] io_out_o,
    output logic [NUM_IO-1:0] io_oe_o,
    output logic              int_sig_o
);

    logic [2*NUM_IO-1:0] ctrl_q, ctrl_d;
    logic [NUM_IO-1:0]   data_q, data_d;
    logic [NUM_IO-1:0]   rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NUM_IO-1:0]   rise_st_q, rise_st_d, fall_st_q, fall_st_d;
    logic [DB_W-1:0]     db_q, db_d, cnt_q, cnt_d;
    logic                int_q, int_d;

    logic [NUM_IO-1:0]   filt, filt_chg, is_out, is_in, rd_data;
    logic                tick;
    logic                wr_ctrl, wr_data, wr_en, wr_st, wr_db;
    logic                unused_bus;

    assign tick    = (cnt_q == db_q);
    assign wr_ctrl = we_i && (addr_i[7:0] == GPIO_CTRL);
    assign wr_data = we_i && (addr_i[7:0] == GPIO_DATA);
    assign wr_en   = we_i && (addr_i[7:0] == GPIO_INT_EN);
    assign wr_st   = we_i && (addr_i[7:0] == GPIO_INT_STATUS);
    assign wr_db   = we_i && (addr_i[7:0] == GPIO_DEBOUNCE);

    assign unused_bus = ^{addr_i[31:8], data_i};

    for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
        gpio_in_filter u_filter (
            .clk        (clk),
            .rst_n      (rst),
            .tick       (tick),
            .pad_i      (io_pin_i[i]),
            .filt_o     (filt[i]),
            .filt_chg_o (filt_chg[i])
        );
    end

    always_comb begin
        is_out  = '0;
        is_in   = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            is_out[i]  = (ctrl_q[2*i +: 2] == GPIO_MODE_OUT);
            is_in[i]   = (ctrl_q[2*i +: 2] == GPIO_MODE_IN);
            rd_data[i] = (is_out[i] & data_q[i]) | (is_in[i] & filt[i]);
        end
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        db_d      = db_q;
        if (wr_ctrl) ctrl_d = data_i[2*NUM_IO-1:0];
        if (wr_data) data_d = data_i[NUM_IO-1:0];
        if (wr_en) begin
            rise_en_d = data_i[NUM_IO-1:0];
            fall_en_d = data_i[16 +: NUM_IO];
        end
        if (wr_db) db_d = data_i[DB_W-1:0];
        cnt_d = (wr_db || tick) ? '0 : cnt_q + DB_W'(1);

        // Clear first, then set, so a new edge wins over a same-cycle W1C.
        rise_st_d = rise_st_q;
        fall_st_d = fall_st_q;
        if (wr_st) begin
            rise_st_d = rise_st_d & ~data_i[NUM_IO-1:0];
            fall_st_d = fall_st_d & ~data_i[16 +: NUM_IO];
        end
        rise_st_d = rise_st_d | (filt_chg & ~filt & is_in & rise_en_q);
        fall_st_d = fall_st_d | (filt_chg &  filt & is_in & fall_en_q);

        int_d = |((rise_st_d & rise_en_d) | (fall_st_d & fall_en_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q    <= '0;
            data_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            rise_st_q <= '0;
            fall_st_q <= '0;
            db_q      <= '0;
            cnt_q     <= '0;
            int_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            rise_st_q <= rise_st_d;
            fall_st_q <= fall_st_d;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            int_q     <= int_d;
        end
    end

    always_comb begin
        data_o = '0;
        case (addr_i[7:0])
            GPIO_CTRL:       data_o[2*NUM_IO-1:0] = ctrl_q;
            GPIO_DATA:       data_o[NUM_IO-1:0]   = rd_data;
            GPIO_INT_EN: begin
                data_o[NUM_IO-1:0]   = rise_en_q;
                data_o[16 +: NUM_IO] = fall_en_q;
            end
            GPIO_INT_STATUS: begin
                data_o[NUM_IO-1:0]   = rise_st_q;
                data_o[16 +: NUM_IO] = fall_st_q;
            end
            GPIO_DEBOUNCE:   data_o[DB_W-1:0]     = db_q;
            default:         data_o = '0;
        endcase
    end

    assign io_oe_o   = is_out;
    assign io_out_o  = data_q;
    assign int_sig_o = int_q;

endmodule

// File: tb/tb_gpio_nch.sv
// Randomised and directed bench for gpio_nch against a cycle-level behavioural model.
module tb_gpio_nch;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we_i = 1'b0;
    logic [31:0]   addr_i = '0;
    logic [31:0]   data_i = '0;
    logic [31:0]   data_o;
    logic [N-1:0]  io_pin_i = '0;
    logic [N-1:0]  io_out_o;
    logic [N-1:0]  io_oe_o;
    logic          int_sig_o;

    int n_pass  = 0;
    int n_total = 0;

    gpio_nch #(.NUM_IO(N), .DB_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .io_pin_i  (io_pin_i),
        .io_out_o  (io_out_o),
        .io_oe_o   (io_oe_o),
        .int_sig_o (int_sig_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: pad history, tick phase, filter and register file.
    bit [1:0]   m_mode [N];
    bit [N-1:0] m_lat, m_ren, m_fen, m_rst, m_fst;
    bit [N-1:0] m_s1, m_s2, m_smp, m_filt;
    int         m_cnt, m_d;
    bit         m_int;

    task automatic m_reset();
        for (int i = 0; i < N; i++) m_mode[i] = 2'b00;
        m_lat = '0; m_ren = '0; m_fen = '0; m_rst = '0; m_fst = '0;
        m_s1 = '0; m_s2 = '0; m_smp = '0; m_filt = '0;
        m_cnt = 0; m_d = 0; m_int = 1'b0;
    endtask

    task automatic m_step();
        bit         tick;
        bit [7:0]   a;
        bit [N-1:0] sr, sf;
        bit         nf;
        tick = (m_cnt == m_d);
        a = addr_i[7:0];
        sr = '0;
        sf = '0;
        for (int i = 0; i < N; i++) begin
            if (tick && m_s2[i] == m_smp[i] && m_s2[i] != m_filt[i]) begin
                nf = m_s2[i];
                if (m_mode[i] == 2'b10) begin
                    sr[i] = nf & m_ren[i];
                    sf[i] = !nf & m_fen[i];
                end
                m_filt[i] = nf;
            end
            if (tick) m_smp[i] = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = io_pin_i[i];
        end
        if (we_i && a == 8'h0C) begin
            m_rst = m_rst & ~data_i[N-1:0];
            m_fst = m_fst & ~data_i[16 +: N];
        end
        m_rst = m_rst | sr;
        m_fst = m_fst | sf;
        m_cnt = tick ? 0 : m_cnt + 1;
        if (we_i) begin
            case (a)
                8'h00: for (int i = 0; i < N; i++) m_mode[i] = data_i[2*i +: 2];
                8'h04: m_lat = data_i[N-1:0];
                8'h08: begin m_ren = data_i[N-1:0]; m_fen = data_i[16 +: N]; end
                8'h10: begin m_d = int'(data_i[15:0]); m_cnt = 0; end
                default: ;
            endcase
        end
        m_int = |((m_rst & m_ren) | (m_fst & m_fen));
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        logic [31:0] r;
        r = '0;
        case (addr[7:0])
            8'h00: for (int i = 0; i < N; i++) r[2*i +: 2] = m_mode[i];
            8'h04: for (int i = 0; i < N; i++)
                       r[i] = (m_mode[i] == 2'b01) ? m_lat[i] :
                              (m_mode[i] == 2'b10) ? m_filt[i] : 1'b0;
            8'h08: begin r[N-1:0] = m_ren; r[16 +: N] = m_fen; end
            8'h0C: begin r[N-1:0] = m_rst; r[16 +: N] = m_fst; end
            8'h10: r = 32'(m_d);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_oe();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = (m_mode[i] == 2'b01);
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else      m_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model_io_out", 32'(io_out_o), 32'(m_lat));
        chk("model_io_oe", 32'(io_oe_o), m_oe());
        chk("model_int", 32'(int_sig_o), 32'(m_int));
        chk("model_data_o", data_o, m_read(addr_i));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we_i = 1'b1; addr_i = a; data_i = d;
        cyc();
        we_i = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr_i = a;
        #1;
        chk(name, data_o, exp);
        cyc();
    endtask

    initial begin
        logic [31:0] offs [7];
        logic [31:0] r;
        int          k;
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h40};

        // Reset held: pads wiggle, nothing leaves reset state.
        cyc();
        for (int i = 0; i < 5; i++) begin
            io_pin_i = N'($urandom);
            rdchk("rst_read", offs[i], 32'h0);
            chk("rst_oe", 32'(io_oe_o), 32'h0);
            chk("rst_int", 32'(int_sig_o), 32'h0);
        end
        io_pin_i = '0;
        rst = 1'b1;
        cycn(6);
        for (int i = 0; i < 5; i++) rdchk("post_rst_read", offs[i], 32'h0);
        chk("post_rst_out", 32'(io_out_o), 32'h0);

        // Output mode on pin 0.
        wr(32'h00, 32'h1);
        wr(32'h04, 32'h3);
        chk("out_oe", 32'(io_oe_o), 32'h1);
        rdchk("out_data_rd", 32'h04, 32'h1);

        // Rising edge interrupt with D = 0: visible after the fourth edge.
        wr(32'h10, 32'h0);
        wr(32'h00, 32'h2);
        wr(32'h08, 32'h1);
        io_pin_i[0] = 1'b1;
        cycn(3);
        chk("rise_int_e3", 32'(int_sig_o), 32'h0);
        rdchk("rise_st_e3", 32'h0C, 32'h0);
        chk("rise_int_e4", 32'(int_sig_o), 32'h1);
        rdchk("rise_st_e4", 32'h0C, 32'h1);
        wr(32'h0C, 32'h1);
        chk("w1c_int", 32'(int_sig_o), 32'h0);
        rdchk("w1c_st", 32'h0C, 32'h0);

        // Set beats clear when the W1C lands on the edge that sets the bit.
        io_pin_i[0] = 1'b0;
        cycn(8);
        rdchk("fall_not_en", 32'h0C, 32'h0);
        io_pin_i[0] = 1'b1;
        cycn(3);
        wr(32'h0C, 32'h1);
        chk("set_wins_int", 32'(int_sig_o), 32'h1);
        rdchk("set_wins_st", 32'h0C, 32'h1);
        wr(32'h0C, 32'hFFFF_FFFF);

        // Debounce with D = 9 on pin 1.
        wr(32'h10, 32'h9);
        wr(32'h00, 32'hA);
        wr(32'h08, 32'h0002_0002);
        wr(32'h0C, 32'hFFFF_FFFF);
        io_pin_i[1] = 1'b1;
        cycn(5);
        io_pin_i[1] = 1'b0;
        cycn(40);
        rdchk("db_pulse", 32'h0C, 32'h0);
        io_pin_i[1] = 1'b1;
        cycn(30);
        rdchk("db_rise", 32'h0C, 32'h2);
        chk("db_rise_int", 32'(int_sig_o), 32'h1);
        io_pin_i[1] = 1'b0;
        cycn(30);
        rdchk("db_fall", 32'h0C, 32'h0002_0002);
        wr(32'h0C, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a debounce window.
        io_pin_i = '0;
        cycn(30);
        wr(32'h0C, 32'hFFFF_FFFF);
        io_pin_i[0] = 1'b1;
        cycn(13);
        #2 rst = 1'b0;
        #1;
        chk("arst_int", 32'(int_sig_o), 32'h0);
        chk("arst_oe", 32'(io_oe_o), 32'h0);
        cyc();
        #1 rst = 1'b1;
        wr(32'h00, 32'h2);
        rdchk("arst_filt_clr", 32'h04, 32'h0);
        cycn(6);
        rdchk("arst_filt_new", 32'h04, 32'h1);
        rdchk("arst_no_st", 32'h0C, 32'h0);

        // Random traffic checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            k = int'($urandom_range(0, 6));
            r = $urandom;
            addr_i = {r[31:8], offs[k][7:0]};
            we_i = ($urandom_range(0, 3) == 0);
            data_i = $urandom;
            if (offs[k] == 32'h10) data_i[15:0] = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                k = int'($urandom_range(0, N-1));
                io_pin_i[k] = ~io_pin_i[k];
            end
            cyc();
        end
        we_i = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
